// File: rtl/per_ctrl_pkg.sv
// Shared types and constants for the period-estimator gear-shift controller.
// Contents: state encoding, period/alpha widths, nominal period and the
// absolute-difference helper used by the stability monitor.
package per_ctrl_pkg;

    localparam int PER_W   = 12;
    localparam int ALPHA_W = 3;
    localparam logic [PER_W-1:0] PER_NOMINAL = 12'h800;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_OVERRIDE = 3'd1,
        ST_ACQUIRE  = 3'd2,
        ST_TRACK    = 3'd3,
        ST_LOCKED   = 3'd4
    } state_t;

    // Unsigned |a - b| without wrap-around.
    function automatic logic [PER_W-1:0] abs_diff(input logic [PER_W-1:0] a,
                                                  input logic [PER_W-1:0] b);
        logic [PER_W-1:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

endpackage

// File: rtl/per_stab_mon.sv
// Period stability monitor: keeps the previous accepted period and classifies
// the current eff_period step size against the lock/unlock tolerances.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   upd          take eff_period as the new reference (accepted sample)
//   load         take load_val as the new reference (entry into acquisition)
//   load_val     reference value used with load
//   eff_period   current estimator period, 6.6 fixed point
//   stable       |delta| <= LOCK_TOL
//   unstable     LOCK_TOL < |delta| <= UNLOCK_TOL
//   unlock       |delta| > UNLOCK_TOL
module per_stab_mon
    import per_ctrl_pkg::*;
#(
    parameter logic [PER_W-1:0] LOCK_TOL   = 12'd4,
    parameter logic [PER_W-1:0] UNLOCK_TOL = 12'd16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd,
    input  logic             load,
    input  logic [PER_W-1:0] load_val,
    input  logic [PER_W-1:0] eff_period,
    output logic             stable,
    output logic             unstable,
    output logic             unlock
);

    logic [PER_W-1:0] prev_per_r;
    logic [PER_W-1:0] delta_s;

    // Reference period register; a load on acquisition entry wins over an update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_per_r <= PER_NOMINAL;
        end else if (load) begin
            prev_per_r <= load_val;
        end else if (upd) begin
            prev_per_r <= eff_period;
        end
    end

    // Step-size classification; exactly one flag is high.
    always_comb begin
        delta_s  = abs_diff(eff_period, prev_per_r);
        stable   = (delta_s <= LOCK_TOL);
        unlock   = (delta_s > UNLOCK_TOL);
        unstable = !stable && !unlock;
    end

endmodule

// File: rtl/per_gear_ctrl.sv
// Sequencing controller for the DPLL edge-period estimator: forces the nominal
// period at start-up, gear-shifts alpha from ALPHA_MIN to ALPHA_MAX as the
// period settles, and reports lock / loss of lock. All outputs registered.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   enable          run controller; low returns it to IDLE
//   sample_vld      estimator accepted a new edge pair this cycle
//   eff_period      estimator effective period (6.6 fixed point)
//   edges_zero      no-signal indication, qualified by sample_vld
//   nominal_per     start-up period, captured on IDLE->OVERRIDE
//   alpha           averaging shift to estimator
//   per_rst_l       estimator rst_l (1 = eff_period overridden)
//   overwrite_effp  estimator override value
//   locked          high while LOCKED
//   lock_lost       one-cycle pulse on LOCKED->ACQUIRE
//   state           current state encoding (debug)
module per_gear_ctrl
    import per_ctrl_pkg::*;
#(
    parameter int                 OVR_SAMPLES  = 4,
    parameter int                 GEAR_SAMPLES = 8,
    parameter int                 LOCK_SAMPLES = 16,
    parameter logic [ALPHA_W-1:0] ALPHA_MIN    = 3'd1,
    parameter logic [ALPHA_W-1:0] ALPHA_MAX    = 3'd5,
    parameter logic [PER_W-1:0]   LOCK_TOL     = 12'd4,
    parameter logic [PER_W-1:0]   UNLOCK_TOL   = 12'd16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               sample_vld,
    input  logic [PER_W-1:0]   eff_period,
    input  logic               edges_zero,
    input  logic [PER_W-1:0]   nominal_per,
    output logic [ALPHA_W-1:0] alpha,
    output logic               per_rst_l,
    output logic [PER_W-1:0]   overwrite_effp,
    output logic               locked,
    output logic               lock_lost,
    output logic [2:0]         state
);

    localparam int CNT_MAX = (GEAR_SAMPLES > LOCK_SAMPLES) ? GEAR_SAMPLES : LOCK_SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int OVR_W   = $clog2(OVR_SAMPLES + 1);

    state_t           state_r;
    logic [PER_W-1:0] nominal_q_r;
    logic [OVR_W-1:0] samp_cnt_r;
    logic [CNT_W-1:0] stable_cnt_r;

    logic [OVR_W-1:0] samp_inc_s;
    logic [CNT_W-1:0] stab_inc_s;
    logic             ovr_done_s;
    logic             mon_upd_s;
    logic             mon_load_s;
    logic             stable_s;
    logic             unstable_s;
    logic             unlock_s;

    // Saturating next-count values and stability-monitor control strobes.
    always_comb begin
        samp_inc_s = (samp_cnt_r == OVR_W'(OVR_SAMPLES)) ? samp_cnt_r : samp_cnt_r + OVR_W'(1);
        stab_inc_s = (stable_cnt_r == CNT_W'(CNT_MAX)) ? stable_cnt_r : stable_cnt_r + CNT_W'(1);
        ovr_done_s = (samp_inc_s >= OVR_W'(OVR_SAMPLES));
        mon_upd_s  = sample_vld && (state_r != ST_IDLE) && (state_r != ST_OVERRIDE);
        mon_load_s = enable && sample_vld && (state_r == ST_OVERRIDE) && ovr_done_s;
    end

    per_stab_mon #(
        .LOCK_TOL   (LOCK_TOL),
        .UNLOCK_TOL (UNLOCK_TOL)
    ) u_stab_mon (
        .clk        (clk),
        .rst        (rst),
        .upd        (mon_upd_s),
        .load       (mon_load_s),
        .load_val   (nominal_q_r),
        .eff_period (eff_period),
        .stable     (stable_s),
        .unstable   (unstable_s),
        .unlock     (unlock_s)
    );

    // Controller FSM with registered outputs; enable and no-signal take priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            alpha          <= ALPHA_MIN;
            per_rst_l      <= 1'b1;
            overwrite_effp <= PER_NOMINAL;
            nominal_q_r    <= PER_NOMINAL;
            locked         <= 1'b0;
            lock_lost      <= 1'b0;
            samp_cnt_r     <= '0;
            stable_cnt_r   <= '0;
        end else begin
            lock_lost <= 1'b0;
            if (!enable) begin
                state_r      <= ST_IDLE;
                per_rst_l    <= 1'b1;
                alpha        <= ALPHA_MIN;
                locked       <= 1'b0;
                samp_cnt_r   <= '0;
                stable_cnt_r <= '0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r        <= ST_OVERRIDE;
                        nominal_q_r    <= nominal_per;
                        overwrite_effp <= nominal_per;
                        per_rst_l      <= 1'b1;
                        alpha          <= ALPHA_MIN;
                    end
                    ST_OVERRIDE: begin
                        if (sample_vld) begin
                            if (ovr_done_s) begin
                                state_r    <= ST_ACQUIRE;
                                per_rst_l  <= 1'b0;
                                samp_cnt_r <= '0;
                            end else begin
                                samp_cnt_r <= samp_inc_s;
                            end
                        end
                    end
                    ST_ACQUIRE, ST_TRACK, ST_LOCKED: begin
                        if (sample_vld) begin
                            if (edges_zero) begin
                                // Signal vanished: re-force the nominal period.
                                state_r      <= ST_OVERRIDE;
                                per_rst_l    <= 1'b1;
                                alpha        <= ALPHA_MIN;
                                locked       <= 1'b0;
                                samp_cnt_r   <= '0;
                                stable_cnt_r <= '0;
                            end else if (unlock_s) begin
                                state_r      <= ST_ACQUIRE;
                                alpha        <= ALPHA_MIN;
                                locked       <= 1'b0;
                                lock_lost    <= (state_r == ST_LOCKED);
                                stable_cnt_r <= '0;
                            end else if (state_r == ST_LOCKED) begin
                                stable_cnt_r <= '0;
                            end else if (unstable_s) begin
                                stable_cnt_r <= '0;
                            end else if ((alpha < ALPHA_MAX) && (stab_inc_s >= CNT_W'(GEAR_SAMPLES))) begin
                                state_r      <= ST_TRACK;
                                alpha        <= alpha + 3'd1;
                                stable_cnt_r <= '0;
                            end else if ((alpha == ALPHA_MAX) && (stab_inc_s >= CNT_W'(LOCK_SAMPLES))) begin
                                state_r      <= ST_LOCKED;
                                locked       <= 1'b1;
                                stable_cnt_r <= '0;
                            end else begin
                                stable_cnt_r <= stab_inc_s;
                            end
                        end
                    end
                    default: begin
                        state_r      <= ST_IDLE;
                        per_rst_l    <= 1'b1;
                        alpha        <= ALPHA_MIN;
                        locked       <= 1'b0;
                        samp_cnt_r   <= '0;
                        stable_cnt_r <= '0;
                    end
                endcase
            end
        end
    end

    assign state = state_r;

endmodule
